// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, decoder
// valid/ready channel and the branch/jump redirect inputs.
// master = fetch unit side, slave = memory/decoder/branch-resolution side.
interface ifetch_if;
  // instruction memory channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // decoder channel
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  // redirect and trap
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus4, fetch_fault,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus4, fetch_fault,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time
// over imem req/ack, presents the word with its PC to the decoder over
// valid/ready, and follows branch/jump redirects, discarding wrong-path data.
// No prefetch: one outstanding request, one presented instruction at most.
// Optional build macro IFETCH_ALIGN_CHK_EN: a redirect to a non-word-aligned
// target traps into a sticky FAULT state (fetch_fault=1) left only by reset.
// Without it the low two target bits are cleared and FAULT is unreachable.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;             // address of the request being issued
  logic [31:0] target_reg, target_next;     // pending redirect target while draining
  logic        pend_fault_reg, pend_fault_next; // pending target is misaligned
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic        valid_reg, valid_next;

  // Redirect target as seen by the FSM, and whether it must trap.
  logic [31:0] redir_pc;
  logic        redir_bad;

`ifdef IFETCH_ALIGN_CHK_EN
  assign redir_pc  = bus.redirect_pc;
  assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      target_reg     <= RESET_PC;
      pend_fault_reg <= 1'b0;
      instr_reg      <= 32'h0000_0000;
      pc_out_reg     <= RESET_PC;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      target_reg     <= target_next;
      pend_fault_reg <= pend_fault_next;
      instr_reg      <= instr_next;
      pc_out_reg     <= pc_out_next;
      valid_reg      <= valid_next;
    end
  end

  // Next-state and datapath update; redirects beat every sequential PC step.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    target_next     = target_reg;
    pend_fault_next = pend_fault_reg;
    instr_next      = instr_reg;
    pc_out_next     = pc_out_reg;
    valid_next      = valid_reg;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            // returning word is wrong-path: drop it and refetch at the target
            if (redir_bad) begin
              state_next = FAULT;
            end else begin
              pc_next = redir_pc;
            end
          end else begin
            instr_next  = bus.imem_rdata;
            pc_out_next = pc_reg;
            valid_next  = 1'b1;
            state_next  = HOLD;
          end
        end else if (bus.redirect) begin
          // request already issued; it must complete before the target is fetched
          target_next     = redir_pc;
          pend_fault_next = redir_bad;
          state_next      = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.imem_ack) begin
          // a redirect arriving with the ack is the latest and wins
          if (bus.redirect) begin
            if (redir_bad) begin
              state_next = FAULT;
            end else begin
              pc_next    = redir_pc;
              state_next = FETCH;
            end
          end else if (pend_fault_reg) begin
            state_next = FAULT;
          end else begin
            pc_next    = target_reg;
            state_next = FETCH;
          end
        end else if (bus.redirect) begin
          target_next     = redir_pc;
          pend_fault_next = redir_bad;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          // held word is dropped (or consumed if ready) either way
          valid_next = 1'b0;
          if (redir_bad) begin
            state_next = FAULT;
          end else begin
            pc_next    = redir_pc;
            state_next = FETCH;
          end
        end else if (bus.instr_ready) begin
          pc_next    = pc_reg + 32'd4;
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end

      FAULT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // A request stays up (with a stable address) until its ack, even when draining.
  assign bus.imem_req    = (state_reg == FETCH) || (state_reg == DRAIN);
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_out   = instr_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.pc_out      = pc_out_reg;
  assign bus.pc_plus4    = pc_out_reg + 32'd4;

`ifdef IFETCH_ALIGN_CHK_EN
  assign bus.fetch_fault = (state_reg == FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule
